rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive cycles B may wait while A wins before B gets forced priority; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_rd  input  5  requester A destination register.
REQ-006 a_data  input  32  requester A write data.
REQ-007 a_ready  output  1  A's write accepted this cycle.
REQ-008 b_valid  input  1  requester B (load/long-latency unit) has a write pending.
REQ-009 b_rd  input  5  requester B destination register.
REQ-010 b_data  input  32  requester B write data.
REQ-011 b_ready  output  1  B's write accepted this cycle.
REQ-012 rf_we  output  1  register-file write enable, registered.
REQ-013 rf_wa  output  5  register-file write address, registered.
REQ-014 rf_wd  output  32  register-file write data, registered.
REQ-015 boost  output  1  high while in state BOOST (B has forced priority).

Function
REQ-016 Transfer: a requester's write is accepted in a cycle when its valid and its ready are both high; ready is combinational from valid and current state.
REQ-017 At most one of a_ready, b_ready is high in any cycle; ready is never high while its valid is low.
REQ-018 States NORM and BOOST, plus 4-bit counter wait_cnt.
REQ-019 NORM: a_valid=1 grants A; else b_valid=1 grants B; else no grant.
REQ-020 BOOST: b_valid=1 grants B; else a_valid=1 grants A.
REQ-021 wait_cnt increments by 1 in each NORM cycle with b_valid=1 and A granted; clears to 0 in any cycle B is granted or b_valid=0.
REQ-022 NORM -> BOOST at the edge where the increment makes wait_cnt reach STARVE_LIMIT; wait_cnt saturates there and does not wrap.
REQ-023 BOOST -> NORM at the edge following any cycle in which B is granted or b_valid=0; wait_cnt clears on that edge.
REQ-024 Latency: a write accepted in cycle N drives rf_we/rf_wa/rf_wd in cycle N+1; the register file captures it at the end of N+1.
REQ-025 No accept in cycle N: rf_we=0 in cycle N+1; rf_wa/rf_wd hold previous values.
REQ-026 A write with rd=0 is accepted (ready=1) but produces rf_we=0 in cycle N+1; x0 writes consume the grant slot.
REQ-027 Simultaneous A and B valid with the same rd: arbitrate per REQ-019/020 with no merging or reordering; the later-granted value is the one left in the register.
REQ-028 Requesters hold valid, rd, data stable until accepted; the block does not check this.
REQ-029 Throughput: one accepted write per cycle when any valid is high; no bubble cycles.

Reset
REQ-030 While rst_n=0: state=NORM, wait_cnt=0, rf_we=0, rf_wa=0, rf_wd=0, boost=0; a_ready/b_ready follow REQ-019 combinationally but no state updates, accepts or writes occur.
REQ-031 Reset asserted mid-operation discards any in-flight registered write (rf_we forced 0 immediately, asynchronously); no write from before reset appears after deassertion.
REQ-032 First possible rf_we=1 is the cycle after the first accept following rst_n deassertion.

Verification
REQ-033 A only: a_valid=1, a_rd=5, a_data=0x1234 for one cycle -> a_ready=1 that cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0x1234; following cycle rf_we=0.
REQ-034 Both valid continuously, STARVE_LIMIT=4, A rd=1/data=0xA, B rd=2/data=0xB -> A granted cycles 0-3, boost=1 in cycle 4, B granted cycle 4, A granted cycle 5 with boost=0; rf_wa sequence 1,1,1,1,2,1 one cycle later.
REQ-035 x0: b_valid=1, b_rd=0, b_data=0xFFFFFFFF, a_valid=0 -> b_ready=1; next cycle rf_we=0; the register-file x0 read still returns 0.
REQ-036 Same rd: a_valid=b_valid=1, both rd=7, a_data=0x11, b_data=0x22, NORM -> A then B accepted on consecutive cycles; rf_wd 0x11 then 0x22; register 7 ends 0x22.
REQ-037 Reset mid-write: accept A (rd=3, data=0x55) in cycle N; rst_n=0 asynchronously during cycle N+1 -> rf_we falls to 0 without a clock edge; register 3 remains 0; after release, state NORM, wait_cnt=0.
REQ-038 Idle then B only: b_valid=1 for 3 cycles, rd=9,10,11 -> b_ready=1 each cycle, boost stays 0, rf_wa 9,10,11 with rf_we=1 on cycles 1-3.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester register-file writeback arbiter.
//   A (ALU) normally wins. B (load / long-latency) gets one cycle of forced
//   priority after waiting STARVE_LIMIT consecutive cycles behind A.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   a_valid/a_rd/a_data/a_ready  requester A handshake (ready combinational)
//   b_valid/b_rd/b_data/b_ready  requester B handshake (ready combinational)
//   rf_we/rf_wa/rf_wd          registered register-file write port
//   boost                      high while B has forced priority
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        boost
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic {NORM, BOOST} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        accept;

  // Grant: priority flips to B only while boosted.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state == BOOST) begin
      b_ready = b_valid;
      a_ready = a_valid & ~b_valid;
    end else begin
      a_ready = a_valid;
      b_ready = b_valid & ~a_valid;
    end
  end

  assign accept  = a_ready | b_ready;
  assign wr_rd   = b_ready ? b_rd   : a_rd;
  assign wr_data = b_ready ? b_data : a_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORM;
      wait_cnt <= 4'd0;
      boost    <= 1'b0;
      rf_we    <= 1'b0;
      rf_wa    <= 5'd0;
      rf_wd    <= 32'd0;
    end else begin
      // x0 writes take the grant slot but never reach the register file;
      // address/data only move on a real write so they hold otherwise.
      rf_we <= accept & (wr_rd != 5'd0);
      if (accept && wr_rd != 5'd0) begin
        rf_wa <= wr_rd;
        rf_wd <= wr_data;
      end

      case (state)
        NORM: begin
          if (b_valid && a_ready) begin
            // B lost to A this cycle: count the wait, boost when it hits limit
            // (counter parks at LIM rather than wrapping).
            if (wait_cnt == LIM - 4'd1) begin
              wait_cnt <= LIM;
              state    <= BOOST;
              boost    <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end else begin
            wait_cnt <= 4'd0;
          end
        end
        BOOST: begin
          if (b_ready || !b_valid) begin
            state    <= NORM;
            boost    <= 1'b0;
            wait_cnt <= 4'd0;
          end
        end
        default: begin
          state    <= NORM;
          boost    <= 1'b0;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic, all
// compared against a behavioural model of the arbitration rules.
module tb_rf_wb_arbiter;

  localparam int LIM = 4;

  logic        clk, rst_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, rf_wa;
  logic [31:0] a_data, b_data, rf_wd;
  logic        rf_we, boost;

  int passed = 0;
  int total  = 0;

  rf_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .boost(boost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the DUT write port; x0 is hardwired to zero.
  logic [31:0] regs [32];
  always @(posedge clk)
    if (rst_n && rf_we && rf_wa != 5'd0) regs[rf_wa] <= rf_wd;

  // Reference model: how many consecutive cycles B has been kept waiting,
  // and the last real write seen on the port.
  int          b_waited;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        obs_a_ready, obs_b_ready, obs_boost;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    b_waited = 0;
    m_wa = 5'd0;
    m_wd = 32'd0;
  endtask

  // One bus cycle: drive at negedge, check grants mid-cycle, then check the
  // registered write port just after the rising edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    logic pri_b, ga, gb, exp_we;
    logic [4:0] rd;
    logic [31:0] d;
    @(negedge clk);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    #1;
    pri_b = (b_waited >= LIM);
    gb = pri_b ? bv : (bv && !av);
    ga = av && !gb;
    obs_a_ready = a_ready; obs_b_ready = b_ready; obs_boost = boost;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    chk("boost", boost, pri_b);
    rd = gb ? brd : ard;
    d  = gb ? bd  : ad;
    exp_we = (ga || gb) && rd != 5'd0;
    if (exp_we) begin m_wa = rd; m_wd = d; end
    if (gb || !bv) b_waited = 0;
    else b_waited++;
    @(posedge clk); #1;
    chk("rf_we", rf_we, exp_we);
    chk("rf_wa", rf_wa, m_wa);
    chk("rf_wd", rf_wd, m_wd);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    rst_n = 1'b0;
    a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
    model_reset();

    // Reset state; ready still follows valid combinationally.
    #2;
    chk("rst_we", rf_we, 1'b0);
    chk("rst_wa", rf_wa, 5'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_boost", boost, 1'b0);
    a_valid = 1'b1; b_valid = 1'b1; a_rd = 5'd4; a_data = 32'h99;
    #1;
    chk("rst_a_ready", a_ready, 1'b1);
    chk("rst_b_ready", b_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_no_write", rf_we, 1'b0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;

    // Single A write, then an idle cycle that must hold address/data.
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("a_only_ready", obs_a_ready, 1'b1);
    chk("a_only_wa", rf_wa, 5'd5);
    chk("a_only_wd", rf_wd, 32'h1234);
    idle();
    chk("a_only_we_off", rf_we, 1'b0);
    chk("a_only_hold_wa", rf_wa, 5'd5);

    // B alone for three cycles: granted each time, never boosted.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(9 + i), 32'h100 + 32'(i));
      chk("b_only_boost", obs_boost, 1'b0);
      chk("b_only_we", rf_we, 1'b1);
      chk("b_only_wa", rf_wa, 5'(9 + i));
    end
    idle();

    // x0 write by B: accepted but no register write.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("x0_ready", obs_b_ready, 1'b1);
    chk("x0_we", rf_we, 1'b0);
    idle();
    chk("x0_reg", regs[0], 32'd0);

    // Same rd from both: A then B, B's value survives.
    step(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    chk("same_rd_wd0", rf_wd, 32'h11);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22);
    chk("same_rd_wd1", rf_wd, 32'h22);
    idle();
    chk("same_rd_reg7", regs[7], 32'h22);

    // Reset mid-write: in-flight write dropped without a clock edge.
    step(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0);
    chk("midrst_we_before", rf_we, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_we_async", rf_we, 1'b0);
    a_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_boost", boost, 1'b0);
    idle();
    idle();
    chk("midrst_reg3", regs[3], 32'd0);

    // Starvation: A wins four cycles, B boosted for one, then back to A.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
      chk("starve_a_ready", obs_a_ready, (i != 4));
      chk("starve_boost", obs_boost, (i == 4));
      chk("starve_wa", rf_wa, (i == 4) ? 5'd2 : 5'd1);
    end
    idle();

    // Random traffic, biased toward contention; rd=0 appears often.
    for (int i = 0; i < 400; i++) begin
      logic av, bv;
      logic [4:0] ard, brd;
      av  = ($urandom_range(0, 99) < 70);
      bv  = ($urandom_range(0, 99) < 70);
      ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      brd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(av, ard, $urandom, bv, brd, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
